// File: rtl/data_island_packet_scheduler.sv
// Data-island slot arbiter: picks one packet source per slot (ACR, audio,
// AVI/Audio/SPD InfoFrames, or null) and holds its contents for the assembler.
module data_island_packet_scheduler #(
  parameter bit          SEND_AUDIO_INFOFRAME = 1'b1,
  parameter bit          SEND_SPD             = 1'b1,
  parameter int unsigned STARVE_LIMIT         = 4
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        acr_tick,
  input  logic [23:0] acr_header,
  input  logic [55:0] acr_sub [3:0],
  input  logic        audio_valid,
  output logic        audio_ready,
  input  logic [23:0] audio_header,
  input  logic [55:0] audio_sub [3:0],
  input  logic [23:0] avi_header,
  input  logic [55:0] avi_sub [3:0],
  input  logic [23:0] aif_header,
  input  logic [55:0] aif_sub [3:0],
  input  logic [23:0] spd_header,
  input  logic [55:0] spd_sub [3:0],
  input  logic        slot_req,
  input  logic        pkt_done,
  output logic        pkt_valid,
  output logic [23:0] pkt_header,
  output logic [55:0] pkt_sub [3:0],
  output logic [2:0]  pkt_source,
  output logic [7:0]  acr_drop_count
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {S_IDLE, S_HOLD} state_t;
  typedef enum logic [2:0] {
    SRC_NULL = 3'd0, SRC_ACR = 3'd1, SRC_AUD = 3'd2,
    SRC_AVI  = 3'd3, SRC_AIF = 3'd4, SRC_SPD = 3'd5
  } src_t;

  state_t      r_state, w_state_nxt;
  logic        r_acr_p, r_avi_p, r_aif_p, r_spd_p;
  logic [3:0]  r_starve;
  logic [7:0]  r_drop;
  logic        r_valid;
  logic [23:0] r_header;
  logic [55:0] r_sub [3:0];
  src_t        r_source;

  logic        w_accept, w_if_pend, w_demote;
  src_t        w_sel;
  logic [23:0] w_header;
  logic [55:0] w_sub [3:0];
  logic        w_g_acr, w_g_aud, w_g_avi, w_g_aif, w_g_spd;

  assign w_if_pend = r_avi_p | r_aif_p | r_spd_p;
  // Audio has won LIMIT slots in a row while InfoFrames waited: let them in.
  assign w_demote  = (r_starve == LIMIT);

  assign w_g_acr = w_accept && (w_sel == SRC_ACR);
  assign w_g_aud = w_accept && (w_sel == SRC_AUD);
  assign w_g_avi = w_accept && (w_sel == SRC_AVI);
  assign w_g_aif = w_accept && (w_sel == SRC_AIF);
  assign w_g_spd = w_accept && (w_sel == SRC_SPD);

  assign audio_ready    = w_g_aud && !reset;
  assign pkt_valid      = r_valid;
  assign pkt_header     = r_header;
  assign pkt_sub        = r_sub;
  assign pkt_source     = r_source;
  assign acr_drop_count = r_drop;

  // FSM state register
  always_ff @(posedge clk_pixel) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, priority selection and source data mux
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sel       = SRC_NULL;
    w_header    = '0;
    for (int i = 0; i < 4; i++) w_sub[i] = '0;

    case (r_state)
      S_IDLE: if (slot_req) begin
        w_accept    = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: if (pkt_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // ACR always first; a demoted audio source falls in behind the InfoFrames
    if (r_acr_p)                       w_sel = SRC_ACR;
    else if (audio_valid && !w_demote) w_sel = SRC_AUD;
    else if (r_avi_p)                  w_sel = SRC_AVI;
    else if (r_aif_p)                  w_sel = SRC_AIF;
    else if (r_spd_p)                  w_sel = SRC_SPD;
    else if (audio_valid)              w_sel = SRC_AUD;

    case (w_sel)
      SRC_ACR: begin w_header = acr_header;   w_sub = acr_sub;   end
      SRC_AUD: begin w_header = audio_header; w_sub = audio_sub; end
      SRC_AVI: begin w_header = avi_header;   w_sub = avi_sub;   end
      SRC_AIF: begin w_header = aif_header;   w_sub = aif_sub;   end
      SRC_SPD: begin w_header = spd_header;   w_sub = spd_sub;   end
      default: ;
    endcase
  end

  // Pending obligations: a new event on the grant edge keeps the flag set
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_acr_p <= 1'b0;
      r_avi_p <= 1'b0;
      r_aif_p <= 1'b0;
      r_spd_p <= 1'b0;
    end else begin
      r_acr_p <= acr_tick | (r_acr_p & ~w_g_acr);
      r_avi_p <= frame_start | (r_avi_p & ~w_g_avi);
      r_aif_p <= (frame_start & SEND_AUDIO_INFOFRAME) | (r_aif_p & ~w_g_aif);
      r_spd_p <= (frame_start & SEND_SPD) | (r_spd_p & ~w_g_spd);
    end
  end

  // Saturating count of ACR ticks that overwrote an unsent ACR
  always_ff @(posedge clk_pixel) begin
    if (reset) r_drop <= '0;
    else if (acr_tick && r_acr_p && !w_g_acr && r_drop != 8'hFF)
      r_drop <= r_drop + 8'd1;
  end

  // Audio run counter: only runs that block InfoFrames are counted
  always_ff @(posedge clk_pixel) begin
    if (reset) r_starve <= '0;
    else if (w_accept) begin
      if (w_g_aud && w_if_pend)
        r_starve <= (r_starve == 4'hF) ? r_starve : r_starve + 4'd1;
      else
        r_starve <= '0;
    end
  end

  // Output registers: load on selection, drop valid when the packet is done
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_header <= '0;
      for (int i = 0; i < 4; i++) r_sub[i] <= '0;
      r_source <= SRC_NULL;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_header <= w_header;
      r_sub    <= w_sub;
      r_source <= w_sel;
    end else if (r_state == S_HOLD && pkt_done) begin
      r_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Bench for the data-island scheduler: two instances (STARVE_LIMIT 4 and 2)
// share stimulus; a behavioural model predicts both every cycle.
module tb_data_island_packet_scheduler;
  logic clk_pixel = 1'b0;
  logic reset = 1'b1, frame_start = 1'b0, acr_tick = 1'b0, audio_valid = 1'b0;
  logic slot_req = 1'b0, pkt_done = 1'b0;
  logic [23:0] acr_header, audio_header, avi_header, aif_header, spd_header;
  logic [55:0] acr_sub [3:0], audio_sub [3:0], avi_sub [3:0], aif_sub [3:0], spd_sub [3:0];

  logic [1:0]  d_ready, d_valid;
  logic [23:0] d_hdr [2];
  logic [55:0] d_sub0 [3:0], d_sub1 [3:0];
  logic [2:0]  d_src [2];
  logic [7:0]  d_drop [2];

  always #5 clk_pixel = ~clk_pixel;

  data_island_packet_scheduler #(.STARVE_LIMIT(4)) u_dut4 (
    .clk_pixel(clk_pixel), .reset(reset), .frame_start(frame_start), .acr_tick(acr_tick),
    .acr_header(acr_header), .acr_sub(acr_sub), .audio_valid(audio_valid),
    .audio_ready(d_ready[0]), .audio_header(audio_header), .audio_sub(audio_sub),
    .avi_header(avi_header), .avi_sub(avi_sub), .aif_header(aif_header), .aif_sub(aif_sub),
    .spd_header(spd_header), .spd_sub(spd_sub), .slot_req(slot_req), .pkt_done(pkt_done),
    .pkt_valid(d_valid[0]), .pkt_header(d_hdr[0]), .pkt_sub(d_sub0),
    .pkt_source(d_src[0]), .acr_drop_count(d_drop[0]));

  data_island_packet_scheduler #(.STARVE_LIMIT(2)) u_dut2 (
    .clk_pixel(clk_pixel), .reset(reset), .frame_start(frame_start), .acr_tick(acr_tick),
    .acr_header(acr_header), .acr_sub(acr_sub), .audio_valid(audio_valid),
    .audio_ready(d_ready[1]), .audio_header(audio_header), .audio_sub(audio_sub),
    .avi_header(avi_header), .avi_sub(avi_sub), .aif_header(aif_header), .aif_sub(aif_sub),
    .spd_header(spd_header), .spd_sub(spd_sub), .slot_req(slot_req), .pkt_done(pkt_done),
    .pkt_valid(d_valid[1]), .pkt_header(d_hdr[1]), .pkt_sub(d_sub1),
    .pkt_source(d_src[1]), .acr_drop_count(d_drop[1]));

  // Model state per instance
  int limit [2] = '{4, 2};
  bit m_acr [2], m_avi [2], m_aif [2], m_spd [2], m_hold [2];
  int m_run [2], m_drop [2];
  bit e_valid [2];
  logic [23:0]  e_hdr [2];
  logic [223:0] e_sub [2];
  int e_src [2];
  int rdy_cnt [2];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] src_hdr(input int s);
    case (s)
      1: return acr_header;
      2: return audio_header;
      3: return avi_header;
      4: return aif_header;
      5: return spd_header;
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [223:0] src_sub(input int s);
    case (s)
      1: return {acr_sub[3], acr_sub[2], acr_sub[1], acr_sub[0]};
      2: return {audio_sub[3], audio_sub[2], audio_sub[1], audio_sub[0]};
      3: return {avi_sub[3], avi_sub[2], avi_sub[1], avi_sub[0]};
      4: return {aif_sub[3], aif_sub[2], aif_sub[1], aif_sub[0]};
      5: return {spd_sub[3], spd_sub[2], spd_sub[1], spd_sub[0]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [223:0] dsub(input int k);
    if (k == 0) return {d_sub0[3], d_sub0[2], d_sub0[1], d_sub0[0]};
    return {d_sub1[3], d_sub1[2], d_sub1[1], d_sub1[0]};
  endfunction

  // Which source wins a slot right now
  function automatic int pick(input int k);
    bit ifp = m_avi[k] || m_aif[k] || m_spd[k];
    bit demoted = (m_run[k] >= limit[k]) && ifp;
    if (m_acr[k]) return 1;
    if (audio_valid && !demoted) return 2;
    if (m_avi[k]) return 3;
    if (m_aif[k]) return 4;
    if (m_spd[k]) return 5;
    if (audio_valid) return 2;
    return 0;
  endfunction

  task automatic model_step(input int k);
    int g;
    bit ifp;
    if (reset) begin
      m_acr[k] = 0; m_avi[k] = 0; m_aif[k] = 0; m_spd[k] = 0; m_hold[k] = 0;
      m_run[k] = 0; m_drop[k] = 0;
      e_valid[k] = 0; e_hdr[k] = '0; e_sub[k] = '0; e_src[k] = 0;
      return;
    end
    g = -1;
    if (!m_hold[k] && slot_req) g = pick(k);
    ifp = m_avi[k] || m_aif[k] || m_spd[k];
    if (acr_tick && m_acr[k] && g != 1 && m_drop[k] < 255) m_drop[k]++;
    if (g >= 0) begin
      e_valid[k] = 1; e_src[k] = g; e_hdr[k] = src_hdr(g); e_sub[k] = src_sub(g);
      m_hold[k] = 1;
      if (g == 2) m_run[k] = ifp ? ((m_run[k] < 15) ? m_run[k] + 1 : 15) : 0;
      else        m_run[k] = 0;
    end else if (m_hold[k] && pkt_done) begin
      m_hold[k] = 0; e_valid[k] = 0;
    end
    m_acr[k] = acr_tick    || (m_acr[k] && g != 1);
    m_avi[k] = frame_start || (m_avi[k] && g != 3);
    m_aif[k] = frame_start || (m_aif[k] && g != 4);
    m_spd[k] = frame_start || (m_spd[k] && g != 5);
  endtask

  task automatic new_contents();
    acr_header = 24'($urandom); audio_header = 24'($urandom); avi_header = 24'($urandom);
    aif_header = 24'($urandom); spd_header = 24'($urandom);
    for (int j = 0; j < 4; j++) begin
      acr_sub[j] = {$urandom, $urandom} >> 8;  audio_sub[j] = {$urandom, $urandom} >> 8;
      avi_sub[j] = {$urandom, $urandom} >> 8;  aif_sub[j] = {$urandom, $urandom} >> 8;
      spd_sub[j] = {$urandom, $urandom} >> 8;
    end
  endtask

  // One clock: check the combinational ready, advance the model, check outputs
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), d_ready[k],
          !reset && !m_hold[k] && slot_req && pick(k) == 2);
      if (d_ready[k] === 1'b1) rdy_cnt[k]++;
    end
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk_pixel); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), d_valid[k], e_valid[k]);
      chk($sformatf("source%0d", k), d_src[k], e_src[k]);
      chk($sformatf("header%0d", k), d_hdr[k], e_hdr[k]);
      chk($sformatf("sub%0d", k), dsub(k), e_sub[k]);
      chk($sformatf("drop%0d", k), d_drop[k], m_drop[k]);
    end
    reset = 0; frame_start = 0; acr_tick = 0; slot_req = 0; pkt_done = 0;
    new_contents();
  endtask

  task automatic slot(output int s0, output int s1);
    slot_req = 1; tick();
    s0 = d_src[0]; s1 = d_src[1];
    pkt_done = 1; tick();
  endtask

  int s0, s1;
  int seq2 [5]  = '{1, 2, 2, 2, 2};
  int seq3 [12] = '{2, 2, 3, 2, 2, 4, 2, 2, 5, 2, 2, 2};

  initial begin
    new_contents();
    reset = 1; tick(); reset = 1; tick();
    chk("rst_valid", d_valid, 2'b00);
    chk("rst_src", d_src[0], 0);
    chk("rst_drop", d_drop[0], 0);

    // Empty slot gives a null packet
    slot_req = 1; tick();
    chk("null_valid", d_valid[0], 1);
    chk("null_src", d_src[0], 0);
    chk("null_hdr", d_hdr[0], 0);
    pkt_done = 1; tick();
    chk("null_done_valid", d_valid[0], 0);

    // ACR first, then audio keeps winning below the limit
    reset = 1; tick();
    frame_start = 1; acr_tick = 1; tick();
    audio_valid = 1; rdy_cnt[0] = 0;
    for (int i = 0; i < 4; i++) begin
      slot(s0, s1); chk($sformatf("prio_slot%0d", i), s0, seq2[i]);
    end
    chk("prio_ready_cnt", rdy_cnt[0], 3);
    slot(s0, s1); chk("prio_slot4", s0, seq2[4]);

    // Starvation guard with limit 2
    reset = 1; tick();
    frame_start = 1; tick();
    for (int i = 0; i < 12; i++) begin
      slot(s0, s1); chk($sformatf("starve_slot%0d", i), s1, seq3[i]);
    end
    audio_valid = 0;

    // ACR drop counting and saturation
    reset = 1; tick();
    acr_tick = 1; tick();
    acr_tick = 1; tick();
    chk("drop_one", d_drop[0], 1);
    repeat (300) begin acr_tick = 1; tick(); end
    chk("drop_sat0", d_drop[0], 255);
    chk("drop_sat1", d_drop[1], 255);

    // frame_start on the AVI grant edge keeps AVI owed
    reset = 1; tick();
    frame_start = 1; tick();
    slot_req = 1; frame_start = 1; tick();
    chk("avi_regrant_first", d_src[0], 3);
    pkt_done = 1; tick();
    slot(s0, s1); chk("avi_regrant_again", s0, 3);

    // Reset during HOLD
    reset = 1; tick();
    frame_start = 1; tick();
    slot_req = 1; tick();
    chk("hold_src", d_src[0], 3);
    reset = 1; tick();
    chk("hold_rst_valid", d_valid[0], 0);
    slot(s0, s1); chk("post_rst_src", s0, 0);

    // Random traffic
    repeat (4000) begin
      reset       = ($urandom_range(199) == 0);
      frame_start = ($urandom_range(39) == 0);
      acr_tick    = ($urandom_range(7) == 0);
      audio_valid = ($urandom_range(2) != 0);
      slot_req    = ($urandom_range(2) == 0);
      pkt_done    = ($urandom_range(2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
